// File: rtl/tdm_demux.sv
// Receive side of the 1-bit time-multiplexed link. It locks onto the frame
// marker, collects one bit per enabled slot, and publishes each complete word.
module tdm_demux #(
  parameter int CHANNELS = 8,
  parameter int SLOT_W   = $clog2(CHANNELS)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                enable,
  input  logic                sync,
  input  logic                din,
  output logic [CHANNELS-1:0] q,
  output logic                valid,
  output logic                frame_err,
  output logic                locked,
  output logic [SLOT_W-1:0]   slot
);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);
  localparam logic [SLOT_W-1:0] ONE_SLOT  = SLOT_W'(1);

  logic [0:0]          state;
  // The last slot's bit goes straight to q, so the shadow holds one bit fewer.
  logic [CHANNELS-2:0] shadow;

  assign locked = (state == RECV);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= HUNT;
      shadow    <= '0;
      q         <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      slot      <= '0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (enable) begin
        case (state)
          HUNT: begin
            if (sync) begin
              shadow    <= '0;
              shadow[0] <= din;
              slot      <= ONE_SLOT;
              state     <= RECV;
            end
          end
          default: begin
            if (sync) begin
              // A marker anywhere but slot 0 restarts the frame here.
              frame_err <= (slot != '0);
              shadow    <= '0;
              shadow[0] <= din;
              slot      <= ONE_SLOT;
            end else if (slot == '0) begin
              frame_err <= 1'b1;
              slot      <= '0;
              state     <= HUNT;
            end else if (slot == LAST_SLOT) begin
              q     <= {din, shadow};
              valid <= 1'b1;
              slot  <= '0;
            end else begin
              shadow[slot] <= din;
              slot         <= slot + ONE_SLOT;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Randomised and directed bench for tdm_demux, checked against a queue-based
// model of the framing rules.
module tb_tdm_demux;

  localparam int CHANNELS = 8;
  localparam int SLOT_W   = 3;

  logic                clock = 1'b0;
  logic                resetn = 1'b0;
  logic                enable = 1'b0;
  logic                sync = 1'b0;
  logic                din = 1'b0;
  logic [CHANNELS-1:0] q;
  logic                valid;
  logic                frame_err;
  logic                locked;
  logic [SLOT_W-1:0]   slot;

  int checks = 0;
  int failures = 0;
  int nvalid = 0;
  int nerr = 0;

  // Model: received bits of the current frame in a queue; its size is the slot.
  bit                m_locked;
  bit                m_bits[$];
  logic [CHANNELS-1:0] m_q;
  bit                m_valid;
  bit                m_err;

  tdm_demux #(.CHANNELS(CHANNELS)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .sync(sync), .din(din),
    .q(q), .valid(valid), .frame_err(frame_err), .locked(locked), .slot(slot)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    m_locked = 0;
    m_bits.delete();
    m_q = '0;
    m_valid = 0;
    m_err = 0;
  endfunction

  function automatic void model_edge(input bit en, input bit s, input bit d);
    m_valid = 0;
    m_err = 0;
    if (!en) return;
    if (!m_locked) begin
      if (s) begin
        m_bits = '{d};
        m_locked = 1;
      end
    end else if (s) begin
      if (m_bits.size() != 0) m_err = 1;
      m_bits = '{d};
    end else if (m_bits.size() == 0) begin
      m_err = 1;
      m_locked = 0;
    end else begin
      m_bits.push_back(d);
      if (m_bits.size() == CHANNELS) begin
        for (int i = 0; i < CHANNELS; i++) m_q[i] = m_bits[i];
        m_valid = 1;
        m_bits.delete();
      end
    end
  endfunction

  task automatic tick(input bit en, input bit s, input bit d);
    enable = en;
    sync = s;
    din = d;
    @(posedge clock);
    model_edge(en, s, d);
    #1;
    if (valid) nvalid++;
    if (frame_err) nerr++;
  endtask

  task automatic send_frame(input logic [CHANNELS-1:0] w, input int gap);
    for (int i = 0; i < CHANNELS; i++) begin
      for (int g = 1; g < gap; g++) tick(1'b0, 1'($urandom), 1'($urandom));
      tick(1'b1, i == 0, w[i]);
    end
  endtask

  task automatic test_reset();
    resetn = 0;
    enable = 0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", q); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    resetn = 1;
    repeat (5) tick(1'b0, 1'($urandom), 1'($urandom));
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL idle_q got=%h exp=00", q); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", valid); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL idle_locked got=%b exp=0", locked); end
    checks++; if (slot !== 3'd0) begin failures++; $display("FAIL idle_slot got=%0d exp=0", slot); end
  endtask

  task automatic test_clean_frame();
    nvalid = 0;
    send_frame(8'b01001101, 1);
    checks++; if (q !== 8'b01001101) begin failures++; $display("FAIL clean_q got=%b exp=01001101", q); end
    checks++; if (q !== m_q) begin failures++; $display("FAIL clean_q_model got=%h exp=%h", q, m_q); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL clean_valid got=%b exp=1", valid); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL clean_locked got=%b exp=1", locked); end
    checks++; if (slot !== 3'd0) begin failures++; $display("FAIL clean_slot got=%0d exp=0", slot); end
    tick(1'b0, 1'b0, 1'b0);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL clean_valid_pulse got=%b exp=0", valid); end
    checks++; if (nvalid !== 1) begin failures++; $display("FAIL clean_nvalid got=%0d exp=1", nvalid); end
  endtask

  task automatic test_gapped();
    send_frame(8'hFF, 1);
    nvalid = 0;
    nerr = 0;
    send_frame(8'b01001101, 3);
    checks++; if (q !== 8'b01001101) begin failures++; $display("FAIL gapped_q got=%b exp=01001101", q); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL gapped_valid got=%b exp=1", valid); end
    checks++; if (nvalid !== 1) begin failures++; $display("FAIL gapped_nvalid got=%0d exp=1", nvalid); end
    checks++; if (nerr !== 0) begin failures++; $display("FAIL gapped_nerr got=%0d exp=0", nerr); end
  endtask

  task automatic test_back_to_back();
    nvalid = 0;
    nerr = 0;
    send_frame(8'hA5, 1);
    checks++; if (q !== 8'hA5 || valid !== 1'b1) begin failures++; $display("FAIL b2b_a got q=%h v=%b exp q=a5 v=1", q, valid); end
    for (int i = 0; i < CHANNELS - 1; i++) begin
      tick(1'b1, i == 0, 1'(8'h3C >> i));
      checks++; if (valid !== 1'b0 || q !== 8'hA5) begin failures++; $display("FAIL b2b_mid%0d got q=%h v=%b exp q=a5 v=0", i, q, valid); end
    end
    tick(1'b1, 1'b0, 1'b0);
    checks++; if (q !== 8'h3C || valid !== 1'b1) begin failures++; $display("FAIL b2b_b got q=%h v=%b exp q=3c v=1", q, valid); end
    checks++; if (nerr !== 0) begin failures++; $display("FAIL b2b_nerr got=%0d exp=0", nerr); end
    checks++; if (nvalid !== 2) begin failures++; $display("FAIL b2b_nvalid got=%0d exp=2", nvalid); end
  endtask

  task automatic test_early_sync();
    logic [CHANNELS-1:0] w;
    w = 8'h96;
    for (int i = 0; i < 4; i++) tick(1'b1, i == 0, 1'($urandom));
    tick(1'b1, 1'b1, w[0]);
    checks++; if (frame_err !== 1'b1 || valid !== 1'b0) begin failures++; $display("FAIL early_err got err=%b v=%b exp err=1 v=0", frame_err, valid); end
    checks++; if (q !== 8'h3C) begin failures++; $display("FAIL early_q got=%h exp=3c", q); end
    checks++; if (slot !== 3'd1 || locked !== 1'b1) begin failures++; $display("FAIL early_slot got=%0d lk=%b exp=1 lk=1", slot, locked); end
    for (int i = 1; i < CHANNELS; i++) tick(1'b1, 1'b0, w[i]);
    checks++; if (q !== 8'h96 || valid !== 1'b1) begin failures++; $display("FAIL early_new got q=%h v=%b exp q=96 v=1", q, valid); end
    // Marker on the last slot counts as an early sync, not a completion.
    for (int i = 0; i < CHANNELS - 1; i++) tick(1'b1, i == 0, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    checks++; if (frame_err !== 1'b1 || valid !== 1'b0 || q !== 8'h96) begin failures++; $display("FAIL last_sync got err=%b v=%b q=%h exp err=1 v=0 q=96", frame_err, valid, q); end
    for (int i = 1; i < CHANNELS; i++) tick(1'b1, 1'b0, 1'b1);
    checks++; if (q !== 8'hFE || valid !== 1'b1) begin failures++; $display("FAIL last_sync_new got q=%h v=%b exp q=fe v=1", q, valid); end
  endtask

  task automatic test_missing_sync();
    send_frame(8'h5A, 1);
    tick(1'b1, 1'b0, 1'b1);
    checks++; if (frame_err !== 1'b1 || locked !== 1'b0) begin failures++; $display("FAIL miss_err got err=%b lk=%b exp err=1 lk=0", frame_err, locked); end
    checks++; if (q !== 8'h5A || slot !== 3'd0) begin failures++; $display("FAIL miss_q got q=%h slot=%0d exp q=5a slot=0", q, slot); end
    nvalid = 0;
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'($urandom));
    checks++; if (locked !== 1'b0 || slot !== 3'd0 || nvalid !== 0 || q !== 8'h5A) begin failures++; $display("FAIL miss_hunt got lk=%b slot=%0d nv=%0d q=%h exp lk=0 slot=0 nv=0 q=5a", locked, slot, nvalid, q); end
    for (int i = 0; i < 5; i++) tick(1'b1, i == 0, 1'b1);
    checks++; if (locked !== 1'b1 || slot !== 3'd5) begin failures++; $display("FAIL relock got lk=%b slot=%0d exp lk=1 slot=5", locked, slot); end
    resetn = 0;
    #1;
    model_reset();
    checks++; if (q !== 8'h00 || locked !== 1'b0 || slot !== 3'd0) begin failures++; $display("FAIL async_rst got q=%h lk=%b slot=%0d exp q=00 lk=0 slot=0", q, locked, slot); end
    #2;
    resetn = 1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_random();
    bit en, s, d;
    for (int n = 0; n < 600; n++) begin
      en = ($urandom_range(0, 9) < 7);
      s = (m_bits.size() == 0);
      if ($urandom_range(0, 19) == 0) s = ~s;
      d = 1'($urandom);
      tick(en, s, d);
      checks++;
      if (q !== m_q || valid !== m_valid || frame_err !== m_err || locked !== m_locked || slot !== 3'(m_bits.size()))
      begin
        failures++;
        $display("FAIL rand%0d got q=%h v=%b e=%b lk=%b slot=%0d exp q=%h v=%b e=%b lk=%b slot=%0d",
                 n, q, valid, frame_err, locked, slot, m_q, m_valid, m_err, m_locked, m_bits.size());
      end
      checks++;
      if (valid && frame_err) begin failures++; $display("FAIL rand_both%0d got v=1 e=1 exp not both", n); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_frame();
    test_gapped();
    test_back_to_back();
    test_early_sync();
    test_missing_sync();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive end of the team's time-multiplexed 1-bit link: the transmit side steps a mux select through CHANNELS sources, one source per slot.
- This block rebuilds the parallel word from the serial stream.
- It tracks frame alignment with a sync marker, samples one bit per enabled slot into a shadow register, and presents the complete word with a one-cycle valid pulse.
- It detects framing errors and re-hunts for alignment; it sits between the board-level serial input pin and the LEDR/HEX display logic.

Parameters:
- CHANNELS, 8, number of slots per frame (min 2); sets the output word width.
- SLOT_W, $clog2(CHANNELS), slot counter width; derived, not overridden.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- enable  input  1  slot strobe; din and sync are sampled only on edges where enable=1.
- sync  input  1  frame marker; high only during slot 0 of a frame.
- din  input  1  serial data bit for the current slot.
- q  output  CHANNELS  last complete frame; q[i] = bit received in slot i.
- valid  output  1  one-cycle pulse: q updated this cycle.
- frame_err  output  1  one-cycle pulse: framing violation detected.
- locked  output  1  high while in RECV state.
- slot  output  SLOT_W  index of the next slot expected.

Behaviour:
- Reset (resetn=0, asynchronous, any time): state=HUNT; q, valid, frame_err, locked, slot and shadow all 0. Reset mid-frame discards the partial frame; q is cleared to 0.
- All outputs are registered. Edges with enable=0 change nothing except valid and frame_err, which return to 0.
- HUNT:
  - enable=1, sync=0: stay in HUNT, no capture.
  - enable=1, sync=1: shadow[0]<=din, slot<=1, go to RECV.
- RECV (locked=1):
  - enable=1, sync=0, 0<slot<CHANNELS-1: shadow[slot]<=din, slot<=slot+1.
  - enable=1, sync=0, slot=CHANNELS-1: q<={din, shadow[CHANNELS-2:0]}, valid<=1 for one cycle, slot<=0, stay in RECV. Latency: q is visible the cycle after the last-slot sampling edge.
  - enable=1, slot=0, sync=1: start a new frame (shadow[0]<=din, slot<=1). Back-to-back frames need no gap.
  - enable=1, slot=0, sync=0: lost alignment. frame_err<=1, go to HUNT, slot<=0, q unchanged.
  - enable=1, sync=1, slot!=0: early sync. frame_err<=1, discard the partial frame, treat this slot as slot 0 (shadow[0]<=din, slot<=1), stay in RECV. q unchanged, no valid.
- sync=1 on the last slot (slot=CHANNELS-1) is an early sync, not a completion: frame_err=1, no valid.
- valid and frame_err are never both 1 in the same cycle.
- The slot counter never exceeds CHANNELS-1; it wraps to 0 only via frame completion.
- Shadow bits from a discarded frame are never visible on q.

Test Plan:
- Reset then idle: resetn=0 for 2 cycles, then 1, enable=0 for 5 cycles -> q=8'h00, valid=0, locked=0, slot=0.
- Clean frame, CHANNELS=8: enable=1 every cycle, sync=1 in slot 0, din sequence slot0..7 = 1,0,1,1,0,0,1,0 -> one cycle after the slot-7 edge, q=8'b01001101, valid=1 for exactly 1 cycle, locked=1, slot=0.
- Gapped strobes: the same frame with enable=1 only every 3rd cycle, and din/sync toggled randomly while enable=0 -> identical q=8'b01001101, a single valid pulse.
- Back-to-back frames: frame A = 8'hA5 followed immediately by frame B = 8'h3C -> q=8'hA5 with valid, then q=8'h3C with valid exactly 8 enabled slots later, frame_err never set.
- Early sync: sync=1 at slot 4 mid-frame -> frame_err pulse, q keeps its previous value, the next 8 slots decode as a new frame and produce valid.
- Missing sync: after a completed frame, slot 0 arrives with sync=0 -> frame_err pulse, locked=0, and no capture until sync=1. Also assert resetn low at slot 5 mid-frame -> q=0 immediately (asynchronous), state HUNT.
